// File: rtl/picorv32_rst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : picorv32_rst_sequencer
//  Description : Reset/restart sequencer for the PicoRV32 demo system.
//                Qualifies a synchronised clock-generator lock, holds the
//                CPU system in reset for a fixed time, then releases it.
//                Each CPU trap restarts the CPU after a delay, until the
//                retry budget runs out and the sequencer parks in FAULT.
//  Revision    : 1.0 - initial release
// ============================================================================
module picorv32_rst_sequencer #(
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned RST_HOLD_CYCLES    = 16,
    parameter int unsigned TRAP_DELAY_CYCLES  = 1250000,
    parameter int unsigned MAX_RESTARTS       = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       locked_i,
    input  logic       trap_i,
    input  logic       clear_i,
    output logic       sys_rst_o,
    output logic       running_o,
    output logic       fault_o,
    output logic [7:0] restart_cnt_o,
    output logic [2:0] state_o
);

    // The shared counter only ever reaches (largest cycle parameter - 1).
    localparam int unsigned c_max_ab  = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ?
                                        LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
    localparam int unsigned c_max_all = (c_max_ab > TRAP_DELAY_CYCLES) ?
                                        c_max_ab : TRAP_DELAY_CYCLES;
    localparam int unsigned c_cnt_w   = (c_max_all > 1) ? $clog2(c_max_all) : 1;

    localparam logic [c_cnt_w-1:0] c_lock_last = c_cnt_w'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(RST_HOLD_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_trap_last = c_cnt_w'(TRAP_DELAY_CYCLES - 1);
    localparam logic [7:0]         c_max_rst   = 8'(MAX_RESTARTS);

    typedef enum logic [2:0] {
        S_WAIT_LOCK = 3'd0,
        S_HOLD      = 3'd1,
        S_RUN       = 3'd2,
        S_TRAP_WAIT = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_next;
    logic [7:0]           r_restart_cnt;
    logic [7:0]           w_restart_next;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 w_locked_s;
    logic                 w_clear_sync;
    logic                 r_sys_rst;
    logic                 r_running;
    logic                 r_fault;

    assign w_locked_s = r_sync2;

    // Two-flop lock synchroniser; a clear from FAULT re-qualifies the lock
    // from scratch so the restart timing matches power-up.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else if (w_clear_sync) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= locked_i;
            r_sync2 <= r_sync1;
        end
    end

    // Next-state, shared counter and restart bookkeeping.
    always_comb begin
        w_next         = r_state;
        w_cnt_next     = '0;
        w_restart_next = r_restart_cnt;
        w_clear_sync   = 1'b0;
        case (r_state)
            S_WAIT_LOCK: begin
                // Counter tracks consecutive high samples; a low sample clears it.
                if (w_locked_s) begin
                    if (r_cnt == c_lock_last) begin
                        w_next = S_HOLD;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (!w_locked_s) begin
                    w_next = S_WAIT_LOCK;
                end else if (r_cnt == c_hold_last) begin
                    w_next = S_RUN;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_RUN: begin
                // Lock loss wins over a simultaneous trap, which is not counted.
                if (!w_locked_s) begin
                    w_next = S_WAIT_LOCK;
                end else if (trap_i) begin
                    if (r_restart_cnt < c_max_rst) begin
                        w_next         = S_TRAP_WAIT;
                        w_restart_next = r_restart_cnt + 8'd1;
                    end else begin
                        w_next = S_FAULT;
                    end
                end
            end
            S_TRAP_WAIT: begin
                if (!w_locked_s) begin
                    w_next = S_WAIT_LOCK;
                end else if (r_cnt == c_trap_last) begin
                    w_next = S_HOLD;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_FAULT: begin
                // Only clear_i leaves FAULT; lock loss is ignored here.
                if (clear_i) begin
                    w_next         = S_WAIT_LOCK;
                    w_restart_next = 8'd0;
                    w_clear_sync   = 1'b1;
                end
            end
            default: begin
                w_next = S_WAIT_LOCK;
            end
        endcase
    end

    // State register and registered output decode of the next state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= S_WAIT_LOCK;
            r_cnt         <= '0;
            r_restart_cnt <= 8'd0;
            r_sys_rst     <= 1'b1;
            r_running     <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_cnt         <= w_cnt_next;
            r_restart_cnt <= w_restart_next;
            r_sys_rst     <= (w_next != S_RUN);
            r_running     <= (w_next == S_RUN);
            r_fault       <= (w_next == S_FAULT);
        end
    end

    assign sys_rst_o     = r_sys_rst;
    assign running_o     = r_running;
    assign fault_o       = r_fault;
    assign restart_cnt_o = r_restart_cnt;
    assign state_o       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_picorv32_rst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_picorv32_rst_sequencer
//  Description : Self-checking bench for picorv32_rst_sequencer: table of
//                directed segments, hand-written corner sequences and a
//                randomized run against a timestamp-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_picorv32_rst_sequencer;

    localparam int LOCK_STABLE_CYCLES = 8;
    localparam int RST_HOLD_CYCLES    = 4;
    localparam int TRAP_DELAY_CYCLES  = 10;
    localparam int MAX_RESTARTS       = 2;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       locked_i;
    logic       trap_i;
    logic       clear_i;
    logic       sys_rst_o;
    logic       running_o;
    logic       fault_o;
    logic [7:0] restart_cnt_o;
    logic [2:0] state_o;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: state code, time of entry, lock streak, restarts.
    int m_st;
    int m_enter;
    int m_now;
    int m_streak;
    int m_restarts;
    bit m_s1;
    bit m_s2;

    typedef struct {
        bit    lk;
        bit    tr;
        bit    cl;
        int    n;
        int    st;
        int    rc;
        string name;
    } vec_t;

    vec_t tbl[$];

    picorv32_rst_sequencer #(
        .LOCK_STABLE_CYCLES (LOCK_STABLE_CYCLES),
        .RST_HOLD_CYCLES    (RST_HOLD_CYCLES),
        .TRAP_DELAY_CYCLES  (TRAP_DELAY_CYCLES),
        .MAX_RESTARTS       (MAX_RESTARTS)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .locked_i      (locked_i),
        .trap_i        (trap_i),
        .clear_i       (clear_i),
        .sys_rst_o     (sys_rst_o),
        .running_o     (running_o),
        .fault_o       (fault_o),
        .restart_cnt_o (restart_cnt_o),
        .state_o       (state_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic void model_reset();
        m_st       = 0;
        m_enter    = 0;
        m_now      = 0;
        m_streak   = 0;
        m_restarts = 0;
        m_s1       = 1'b0;
        m_s2       = 1'b0;
    endfunction

    // One rising edge of the specified behaviour, using inputs seen at that edge.
    function automatic void model_step(bit lk, bit tr, bit cl);
        bit ls;
        int nxt;
        ls    = m_s2;
        nxt   = m_st;
        m_now = m_now + 1;
        m_s2  = m_s1;
        m_s1  = lk;
        case (m_st)
            0: begin
                if (ls) begin
                    m_streak = m_streak + 1;
                    if (m_streak == LOCK_STABLE_CYCLES) nxt = 1;
                end else begin
                    m_streak = 0;
                end
            end
            1: if (!ls) nxt = 0; else if (m_now - m_enter == RST_HOLD_CYCLES) nxt = 2;
            2: begin
                if (!ls) nxt = 0;
                else if (tr) begin
                    if (m_restarts < MAX_RESTARTS) begin
                        nxt = 3;
                        m_restarts = m_restarts + 1;
                    end else begin
                        nxt = 4;
                    end
                end
            end
            3: if (!ls) nxt = 0; else if (m_now - m_enter == TRAP_DELAY_CYCLES) nxt = 1;
            default: begin
                if (cl) begin
                    nxt        = 0;
                    m_restarts = 0;
                    m_s1       = 1'b0;
                    m_s2       = 1'b0;
                end
            end
        endcase
        if (nxt != m_st) begin
            m_st     = nxt;
            m_enter  = m_now;
            m_streak = 0;
        end
    endfunction

    task automatic check_outputs(string tag, int st, int rc);
        bit ok;
        ok = (state_o == 3'(st)) && (restart_cnt_o == 8'(rc)) &&
             (sys_rst_o == (st != 2)) && (running_o == (st == 2)) &&
             (fault_o == (st == 4));
        n_vec = n_vec + 1;
        if (!ok) begin
            n_bad = n_bad + 1;
            $display("FAIL %s @%0t: got state=%0d cnt=%0d rst=%0b run=%0b flt=%0b, expected state=%0d cnt=%0d rst=%0b run=%0b flt=%0b",
                     tag, $time, state_o, restart_cnt_o, sys_rst_o, running_o, fault_o,
                     st, rc, (st != 2), (st == 2), (st == 4));
        end
    endtask

    task automatic cycle(bit lk, bit tr, bit cl);
        locked_i = lk;
        trap_i   = tr;
        clear_i  = cl;
        @(posedge clk_i);
        model_step(lk, tr, cl);
        #1;
        check_outputs("model", m_st, m_restarts);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        int k;
        rst_i    = 1'b1;
        locked_i = 1'b0;
        trap_i   = 1'b0;
        clear_i  = 1'b0;
        model_reset();

        //            lk tr cl  n  st rc  name
        tbl.push_back('{1, 0, 0, 13, 1, 0, "pwr_hold"});
        tbl.push_back('{1, 0, 0,  1, 2, 0, "pwr_run"});
        tbl.push_back('{1, 0, 1,  1, 2, 0, "clear_in_run"});
        tbl.push_back('{1, 1, 0,  1, 3, 1, "trap1"});
        tbl.push_back('{1, 0, 0,  9, 3, 1, "trap_wait"});
        tbl.push_back('{1, 0, 0,  1, 1, 1, "trap_to_hold"});
        tbl.push_back('{1, 0, 0,  3, 1, 1, "hold_again"});
        tbl.push_back('{1, 0, 0,  1, 2, 1, "rerun1"});
        tbl.push_back('{1, 1, 0,  1, 3, 2, "trap2"});
        tbl.push_back('{1, 0, 0, 14, 2, 2, "rerun2"});
        tbl.push_back('{1, 1, 0,  1, 4, 2, "trap3_fault"});
        tbl.push_back('{0, 0, 0,  3, 4, 2, "lockloss_in_fault"});
        tbl.push_back('{1, 0, 1,  1, 0, 0, "clear_fault"});
        tbl.push_back('{1, 0, 0, 13, 1, 0, "clear_hold"});
        tbl.push_back('{1, 0, 0,  1, 2, 0, "clear_rerun"});
        tbl.push_back('{1, 1, 0,  1, 3, 1, "trap_a"});
        tbl.push_back('{1, 0, 0, 14, 2, 1, "rerun_a"});
        tbl.push_back('{0, 0, 0,  2, 2, 1, "lock_drop_in_sync"});
        tbl.push_back('{0, 1, 0,  1, 0, 1, "lockloss_beats_trap"});
        tbl.push_back('{1, 0, 0,  5, 0, 1, "glitch_pre"});
        tbl.push_back('{0, 0, 0,  1, 0, 1, "glitch_low"});
        tbl.push_back('{1, 0, 0,  9, 0, 1, "no_early_release"});
        tbl.push_back('{1, 0, 0,  1, 1, 1, "glitch_hold"});
        tbl.push_back('{1, 0, 0,  3, 1, 1, "glitch_hold2"});
        tbl.push_back('{1, 0, 0,  1, 2, 1, "glitch_run"});

        // Reset values while rst_i is still held.
        #2;
        check_outputs("reset_state", 0, 0);
        do_reset();

        foreach (tbl[i]) begin
            for (int c = 0; c < tbl[i].n; c++) cycle(tbl[i].lk, tbl[i].tr, tbl[i].cl);
            check_outputs(tbl[i].name, tbl[i].st, tbl[i].rc);
        end

        // Asynchronous reset in the middle of TRAP_WAIT, between edges.
        cycle(1, 1, 0);
        check_outputs("trap_before_rst", 3, 2);
        repeat (3) cycle(1, 0, 0);
        #2;
        rst_i = 1'b1;
        #1;
        check_outputs("async_rst_mid_trap", 0, 0);
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Power-up latency measured edge by edge, bounded.
        k = 0;
        while (sys_rst_o && k < 100) begin
            cycle(1, 0, 0);
            k = k + 1;
        end
        n_vec = n_vec + 1;
        if (k != 2 + LOCK_STABLE_CYCLES + RST_HOLD_CYCLES) begin
            n_bad = n_bad + 1;
            $display("FAIL release_latency: got %0d edges, expected %0d",
                     k, 2 + LOCK_STABLE_CYCLES + RST_HOLD_CYCLES);
        end

        // Randomized traffic against the reference model.
        for (int r = 0; r < 4000; r++) begin
            cycle(($urandom_range(0, 63) != 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 999) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
